// File: rtl/neuron_lut_scheduler.sv
// neuron_lut_scheduler: time-multiplexes one shared neuron LUT port across a layer frame.
// Optional performance counters are built when NEURON_SCHED_PERF_EN is defined. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module neuron_lut_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 2,
  parameter int LUT_LATENCY = 1,
  parameter int SEL_BITS    = $clog2(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  input  logic                            sched_flush,
  output logic                            lut_req,
  output logic [SEL_BITS-1:0]             lut_sel,
  output logic [IN_BITS-1:0]              lut_addr,
  input  logic [OUT_BITS-1:0]             lut_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data
`ifdef NEURON_SCHED_PERF_EN
  ,
  output logic [31:0]                     perf_busy_cycles,
  output logic [31:0]                     perf_frames
`endif
);

  localparam int                 CNT_BITS = $clog2(NUM_NEURONS + 1);
  localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(NUM_NEURONS - 1);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(NUM_NEURONS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            r_in_ready;
  logic                            r_out_valid;
  logic [NUM_NEURONS*IN_BITS-1:0]  r_frame;
  logic [NUM_NEURONS*OUT_BITS-1:0] r_out_data;
  logic [SEL_BITS-1:0]             r_idx;
  logic [CNT_BITS-1:0]             r_ret_cnt;
  logic [CNT_BITS-1:0]             w_ret_cnt_nxt;
  logic                            w_accept;
  logic                            w_flush;
  logic                            w_issue;
  logic                            w_ret_vld;
  logic                            w_ret_wr;
  logic [SEL_BITS-1:0]             w_ret_idx;

  assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready && !sched_flush;
  assign w_flush  = sched_flush && (r_state != ST_IDLE);
  // A flush kills the lookup of the cycle it arrives in.
  assign w_issue  = (r_state == ST_ISSUE) && !sched_flush;

  assign lut_req   = w_issue;
  assign lut_sel   = w_issue ? r_idx : '0;
  assign lut_addr  = w_issue ? r_frame[r_idx*IN_BITS +: IN_BITS] : '0;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  generate
    if (LUT_LATENCY == 0) begin : g_ret_comb
      assign w_ret_vld = w_issue;
      assign w_ret_idx = r_idx;
    end else begin : g_ret_pipe
      logic [LUT_LATENCY-1:0] r_pv;
      logic [SEL_BITS-1:0]    r_pidx [LUT_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pv <= '0;
          for (int i = 0; i < LUT_LATENCY; i++) r_pidx[i] <= '0;
        end else if (w_flush) begin
          r_pv <= '0;
        end else begin
          r_pv[0]   <= w_issue;
          r_pidx[0] <= r_idx;
          for (int i = 1; i < LUT_LATENCY; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_pidx[i] <= r_pidx[i-1];
          end
        end
      end

      assign w_ret_vld = r_pv[LUT_LATENCY-1];
      assign w_ret_idx = r_pidx[LUT_LATENCY-1];
    end
  endgenerate

  assign w_ret_wr      = w_ret_vld && !w_flush;
  assign w_ret_cnt_nxt = r_ret_cnt + CNT_BITS'(w_ret_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Completion looks at the count including this cycle's return so out_valid is not delayed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (r_idx == LAST_IDX)
                  w_state_nxt = (w_ret_cnt_nxt == FULL_CNT) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (w_ret_cnt_nxt == FULL_CNT) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_frame     <= '0;
      r_out_data  <= '0;
      r_idx       <= '0;
      r_ret_cnt   <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_frame    <= in_data;
        r_out_data <= '0;
        r_idx      <= '0;
        r_ret_cnt  <= '0;
      end else begin
        if (w_issue) r_idx <= r_idx + SEL_BITS'(1);
        if (w_ret_wr) begin
          r_out_data[w_ret_idx*OUT_BITS +: OUT_BITS] <= lut_data;
          r_ret_cnt <= w_ret_cnt_nxt;
        end
      end
    end
  end

`ifdef NEURON_SCHED_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_frames;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy   <= '0;
      r_perf_frames <= '0;
    end else begin
      if ((r_state != ST_IDLE) && (r_perf_busy != 32'hFFFF_FFFF))
        r_perf_busy <= r_perf_busy + 32'd1;
      if ((r_state == ST_DONE) && out_ready && (r_perf_frames != 32'hFFFF_FFFF))
        r_perf_frames <= r_perf_frames + 32'd1;
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_frames      = r_perf_frames;
`else
  // Counters are not built in this configuration.
`endif

endmodule

`default_nettype wire
